// File: rtl/scpad_wr_router_if.sv
// Write-router request, response and completion types, plus the bundle that carries
// FE/BE requests, the selected request to the bank stage and completion responses.
package scpad_wr_pkg;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  dim;
    logic [3:0]  xbar;
    logic [31:0] wdata;
  } wr_req_t;

  typedef struct packed {
    logic        valid;
    src_t        src;
    logic [3:0]  xbar;
    logic [31:0] wdata;
  } sel_wr_req_t;

  typedef struct packed {
    logic complete;
  } wr_res_t;

endpackage

interface scpad_wr_router_if #(
  parameter int unsigned TAG_DEPTH = 4
);
  import scpad_wr_pkg::*;

  logic                       fe_wr_valid;
  wr_req_t                    fe_wr_req;
  logic                       fe_wr_ready;
  logic                       be_wr_valid;
  wr_req_t                    be_wr_req;
  logic                       be_wr_ready;
  sel_wr_req_t                sel_wr_req;
  logic                       sel_wr_ready;
  logic                       bank_wr_done;
  wr_res_t                    fe_wr_res;
  wr_res_t                    be_wr_res;
  logic [$clog2(TAG_DEPTH):0] outstanding;
  logic                       err;

  modport slave (
    input  fe_wr_valid, fe_wr_req, be_wr_valid, be_wr_req, sel_wr_ready, bank_wr_done,
    output fe_wr_ready, be_wr_ready, sel_wr_req, fe_wr_res, be_wr_res, outstanding, err
  );

  modport master (
    output fe_wr_valid, fe_wr_req, be_wr_valid, be_wr_req, sel_wr_ready, bank_wr_done,
    input  fe_wr_ready, be_wr_ready, sel_wr_req, fe_wr_res, be_wr_res, outstanding, err
  );

endinterface

// File: rtl/scpad_wr_router.sv
// Scratchpad write router: BE-priority arbitration with FE anti-starvation, a registered
// output stage, and an in-order source-tag FIFO steering bank completions back to FE/BE.
module scpad_wr_router
  import scpad_wr_pkg::*;
#(
  parameter int unsigned TAG_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  scpad_wr_router_if.slave bus
);

  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  sel_wr_req_t          sel_q;
  wr_res_t              fe_res_q, be_res_q;
  logic [TAG_DEPTH-1:0] tag_q;  // 1 = BE
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [StW-1:0]       starve_q, starve_d;
  logic                 err_q;

  logic can_issue, grant_fe, grant_be, push, pop, starved;

  // Space check uses the registered count only: a same-cycle pop never frees a slot.
  assign can_issue = (!sel_q.valid || bus.sel_wr_ready) && (count_q < CntW'(TAG_DEPTH));
  assign starved   = (starve_q == StW'(STARVE_LIMIT));

  always_comb begin
    grant_fe = 1'b0;
    grant_be = 1'b0;
    if (can_issue) begin
      if (bus.fe_wr_valid && bus.be_wr_valid) begin
        grant_fe = starved;
        grant_be = !starved;
      end else begin
        grant_fe = bus.fe_wr_valid;
        grant_be = bus.be_wr_valid;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.fe_wr_valid || grant_fe) begin
      starve_d = '0;
    end else if (grant_be && !starved) begin
      starve_d = starve_q + StW'(1);
    end
  end

  assign push = grant_fe || grant_be;
  assign pop  = bus.bank_wr_done && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      fe_res_q <= '0;
      be_res_q <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;

      if (push) begin
        sel_q.valid <= 1'b1;
        sel_q.src   <= grant_be ? SRC_BE : SRC_FE;
        sel_q.xbar  <= grant_be ? bus.be_wr_req.xbar : bus.fe_wr_req.xbar;
        sel_q.wdata <= grant_be ? bus.be_wr_req.wdata : bus.fe_wr_req.wdata;
        tag_q[wr_ptr_q] <= grant_be;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end else if (bus.sel_wr_ready) begin
        sel_q.valid <= 1'b0;
      end

      fe_res_q.complete <= pop && !tag_q[rd_ptr_q];
      be_res_q.complete <= pop && tag_q[rd_ptr_q];
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end

      if (bus.bank_wr_done && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.fe_wr_ready = grant_fe;
  assign bus.be_wr_ready = grant_be;
  assign bus.sel_wr_req  = sel_q;
  assign bus.fe_wr_res   = fe_res_q;
  assign bus.be_wr_res   = be_res_q;
  assign bus.outstanding = count_q;
  assign bus.err         = err_q;

  // Address and dimension fields are intentionally dropped here.
  logic unused_fields;
  assign unused_fields = ^{bus.fe_wr_req.addr, bus.fe_wr_req.dim,
                           bus.be_wr_req.addr, bus.be_wr_req.dim};

endmodule

// File: tb/tb_scpad_wr_router.sv
// Directed bench for scpad_wr_router: single write, starvation pattern, backpressure,
// FIFO fill, completion ordering, empty-FIFO error and async reset.
module tb_scpad_wr_router;
  import scpad_wr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  scpad_wr_router_if #(.TAG_DEPTH(4)) bus ();

  scpad_wr_router #(
    .TAG_DEPTH   (4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_req_t mk_req(input logic [3:0] xbar, input logic [31:0] wdata);
    wr_req_t r;
    r.addr  = 32'hDEAD_0000 | {28'd0, xbar};
    r.dim   = 4'h5;
    r.xbar  = xbar;
    r.wdata = wdata;
    return r;
  endfunction

  logic starve_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};  // 1 = FE granted
  logic order_exp  [3]  = '{1, 0, 1};                       // 1 = FE completion

  initial begin
    bus.fe_wr_valid  = 1'b0;
    bus.be_wr_valid  = 1'b0;
    bus.fe_wr_req    = '0;
    bus.be_wr_req    = '0;
    bus.sel_wr_ready = 1'b1;
    bus.bank_wr_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_sel_valid", 64'(bus.sel_wr_req.valid), 64'd0);
    check("rst_sel_src", 64'(bus.sel_wr_req.src), 64'(SRC_FE));
    check("rst_outstanding", 64'(bus.outstanding), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_res", 64'({bus.fe_wr_res.complete, bus.be_wr_res.complete}), 64'd0);

    // Single FE write
    bus.fe_wr_valid = 1'b1;
    bus.fe_wr_req   = mk_req(4'h3, 32'hAABB_CCDD);
    #1;
    check("t1_fe_ready", 64'(bus.fe_wr_ready), 64'd1);
    check("t1_be_ready", 64'(bus.be_wr_ready), 64'd0);
    cyc();
    bus.fe_wr_valid = 1'b0;
    check("t1_sel_valid", 64'(bus.sel_wr_req.valid), 64'd1);
    check("t1_sel_src", 64'(bus.sel_wr_req.src), 64'(SRC_FE));
    check("t1_sel_xbar", 64'(bus.sel_wr_req.xbar), 64'h3);
    check("t1_sel_wdata", 64'(bus.sel_wr_req.wdata), 64'hAABB_CCDD);
    check("t1_outstanding1", 64'(bus.outstanding), 64'd1);
    for (int i = 0; i < 4; i++) cyc();
    check("t1_sel_cleared", 64'(bus.sel_wr_req.valid), 64'd0);
    check("t1_no_early_res", 64'(bus.fe_wr_res.complete), 64'd0);
    bus.bank_wr_done = 1'b1;
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t1_fe_res", 64'(bus.fe_wr_res.complete), 64'd1);
    check("t1_be_res", 64'(bus.be_wr_res.complete), 64'd0);
    check("t1_outstanding0", 64'(bus.outstanding), 64'd0);
    cyc();
    check("t1_fe_res_once", 64'(bus.fe_wr_res.complete), 64'd0);

    // Starvation protection, both sources valid continuously
    bus.fe_wr_req = mk_req(4'h1, 32'h1111_1111);
    bus.be_wr_req = mk_req(4'h2, 32'h2222_2222);
    for (int i = 0; i < 10; i++) begin
      bus.fe_wr_valid  = 1'b1;
      bus.be_wr_valid  = 1'b1;
      bus.bank_wr_done = (i > 0);
      #1;
      check($sformatf("t2_fe_ready%0d", i), 64'(bus.fe_wr_ready), 64'(starve_exp[i]));
      check($sformatf("t2_be_ready%0d", i), 64'(bus.be_wr_ready), 64'(!starve_exp[i]));
      cyc();
      check($sformatf("t2_src%0d", i), 64'(bus.sel_wr_req.src),
            starve_exp[i] ? 64'(SRC_FE) : 64'(SRC_BE));
      if (i > 0) begin
        check($sformatf("t2_fe_res%0d", i), 64'(bus.fe_wr_res.complete),
              64'(starve_exp[i-1]));
      end
    end
    bus.fe_wr_valid = 1'b0;
    bus.be_wr_valid = 1'b0;
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t2_last_fe_res", 64'(bus.fe_wr_res.complete), 64'd1);
    check("t2_outstanding", 64'(bus.outstanding), 64'd0);
    check("t2_err", 64'(bus.err), 64'd0);

    // Backpressure
    bus.sel_wr_ready = 1'b0;
    bus.be_wr_valid  = 1'b1;
    bus.be_wr_req    = mk_req(4'hA, 32'h0000_00AA);
    #1;
    check("t3_be_ready_first", 64'(bus.be_wr_ready), 64'd1);
    cyc();
    bus.be_wr_req = mk_req(4'hB, 32'h0000_00BB);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3_readys_stall%0d", i),
            64'({bus.fe_wr_ready, bus.be_wr_ready}), 64'd0);
      check($sformatf("t3_sel_hold%0d", i),
            64'({bus.sel_wr_req.valid, bus.sel_wr_req.xbar}), 64'h1A);
      cyc();
    end
    bus.sel_wr_ready = 1'b1;
    #1;
    check("t3_release_ready", 64'(bus.be_wr_ready), 64'd1);
    cyc();
    bus.be_wr_valid = 1'b0;
    check("t3_sel_next", 64'({bus.sel_wr_req.valid, bus.sel_wr_req.xbar}), 64'h1B);
    check("t3_outstanding", 64'(bus.outstanding), 64'd2);
    bus.bank_wr_done = 1'b1;
    cyc();
    check("t3_be_res0", 64'(bus.be_wr_res.complete), 64'd1);
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t3_be_res1", 64'(bus.be_wr_res.complete), 64'd1);
    check("t3_drained", 64'(bus.outstanding), 64'd0);

    // Fill the tag FIFO
    bus.be_wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.be_wr_req = mk_req(4'(i), 32'(i));
      #1;
      check($sformatf("t4_fill_ready%0d", i), 64'(bus.be_wr_ready), 64'd1);
      cyc();
    end
    check("t4_full", 64'(bus.outstanding), 64'd4);
    check("t4_full_ready", 64'(bus.be_wr_ready), 64'd0);
    cyc();
    check("t4_still_full", 64'(bus.outstanding), 64'd4);
    bus.bank_wr_done = 1'b1;
    #1;
    check("t4_pop_no_free", 64'(bus.be_wr_ready), 64'd0);
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t4_pop_res", 64'(bus.be_wr_res.complete), 64'd1);
    check("t4_pop_count", 64'(bus.outstanding), 64'd3);
    #1;
    check("t4_resume", 64'(bus.be_wr_ready), 64'd1);
    cyc();
    bus.be_wr_valid = 1'b0;
    check("t4_refull", 64'(bus.outstanding), 64'd4);
    bus.bank_wr_done = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    bus.bank_wr_done = 1'b0;
    check("t4_drained", 64'(bus.outstanding), 64'd0);

    // Completion ordering FE, BE, FE
    bus.fe_wr_valid = 1'b1;
    cyc();
    bus.fe_wr_valid = 1'b0;
    bus.be_wr_valid = 1'b1;
    cyc();
    bus.be_wr_valid = 1'b0;
    bus.fe_wr_valid = 1'b1;
    cyc();
    bus.fe_wr_valid = 1'b0;
    check("t5_outstanding", 64'(bus.outstanding), 64'd3);
    bus.bank_wr_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("t5_order%0d", i),
            64'({bus.fe_wr_res.complete, bus.be_wr_res.complete}),
            order_exp[i] ? 64'b10 : 64'b01);
    end
    bus.bank_wr_done = 1'b0;
    cyc();
    check("t5_drained", 64'(bus.outstanding), 64'd0);

    // Completion with empty FIFO, then async reset with writes outstanding
    bus.bank_wr_done = 1'b1;
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t6_err_set", 64'(bus.err), 64'd1);
    check("t6_no_res", 64'({bus.fe_wr_res.complete, bus.be_wr_res.complete}), 64'd0);
    bus.fe_wr_valid = 1'b1;
    cyc();
    cyc();
    bus.fe_wr_valid = 1'b0;
    check("t6_err_sticky", 64'(bus.err), 64'd1);
    check("t6_outstanding2", 64'(bus.outstanding), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_outstanding", 64'(bus.outstanding), 64'd0);
    check("t6_rst_err", 64'(bus.err), 64'd0);
    check("t6_rst_sel", 64'(bus.sel_wr_req.valid), 64'd0);
    cyc();
    rst = 1'b0;
    bus.bank_wr_done = 1'b1;
    cyc();
    bus.bank_wr_done = 1'b0;
    check("t6_dropped_err", 64'(bus.err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scpad_wr_router.md
Name: scpad_wr_router

Overview:
- Write-side router placed directly upstream of the scratchpad bank/crossbar write stage.
- Arbitrates between the frontend (FE) and backend (BE) `wr_req_t` streams and emits one registered `sel_wr_req_t` per accepted request.
- Keeps an in-order FIFO of source tags for outstanding writes. Uses it to steer bank write completions back to FE or BE as `wr_res_t` pulses.
- BE has priority. FE is protected from starvation by a bounded-grant counter.

Parameters:
- TAG_DEPTH, 4, maximum outstanding writes (tag FIFO depth, power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive BE grants with FE waiting after which FE wins one arbitration (≥1).

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous active-high reset.
- fe_wr_valid  in  1  FE request valid.
- fe_wr_req  in  $bits(wr_req_t)  FE request payload.
- fe_wr_ready  out  1  FE request accepted this cycle (valid&ready).
- be_wr_valid  in  1  BE request valid.
- be_wr_req  in  $bits(wr_req_t)  BE request payload.
- be_wr_ready  out  1  BE request accepted.
- sel_wr_req  out  $bits(sel_wr_req_t)  selected request to bank stage; .valid is the output valid.
- sel_wr_ready  in  1  bank stage accepts sel_wr_req this cycle.
- bank_wr_done  in  1  one write completed at banks, strictly in issue order.
- fe_wr_res  out  $bits(wr_res_t)  .complete pulses one cycle for an FE write completion.
- be_wr_res  out  $bits(wr_res_t)  .complete pulses one cycle for a BE write completion.
- outstanding  out  $clog2(TAG_DEPTH)+1  number of tags in FIFO.
- err  out  1  sticky: bank_wr_done received with empty tag FIFO.

Behaviour:
- Reset values:
  - sel_wr_req all zero (.valid=0, .src=SRC_FE).
  - fe_wr_res and be_wr_res zero; outstanding=0; err=0.
  - Tag FIFO empty; starve_cnt=0.
- Output stage is one register. `can_issue = (!sel_wr_req.valid | sel_wr_ready) & (outstanding < TAG_DEPTH)`. A pop on the same cycle does not free space when the FIFO is full.
- Grant, combinational:
  - If !can_issue: no grant.
  - Else if both valid: BE wins unless starve_cnt==STARVE_LIMIT, in which case FE wins.
  - Else the single valid source wins.
- fe_wr_ready and be_wr_ready are asserted only for the granted source. They are never both 1, and are 0 when its valid is 0. Upstream holds valid and payload stable until ready.
- On grant in cycle N, in cycle N+1:
  - sel_wr_req.valid=1.
  - .src = SRC_BE or SRC_FE.
  - .xbar and .wdata copied from the winner.
  - The src tag is pushed into the FIFO at the same edge.
- sel_wr_req holds unchanged while valid & !sel_wr_ready. On sel_wr_ready with no new grant, .valid clears; other fields may hold.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a BE grant while fe_wr_valid=1.
  - Clears on an FE grant, or in any cycle where fe_wr_valid=0.
- Completion:
  - On bank_wr_done with FIFO non-empty, pop the head tag.
  - Next cycle, pulse the complete of fe_wr_res or be_wr_res for that tag, for exactly one cycle.
  - A push and a pop in the same cycle are both performed; outstanding is unchanged.
- bank_wr_done with empty FIFO: no pop, no response pulse, err set until reset.
- FIFO pointers wrap modulo TAG_DEPTH; outstanding counts 0..TAG_DEPTH inclusive.
- Reset mid-operation clears all state immediately (async). Completions arriving afterwards for dropped tags set err.
- Width rules: fields copied bit-exact from wr_req_t to sel_wr_req_t. Address and dimension fields are not forwarded by this block.

Test Plan:
- Single FE write, sel_wr_ready=1: fe_wr_ready=1 at cycle 0 → sel_wr_req.valid=1, .src=SRC_FE at cycle 1. bank_wr_done at cycle 5 → fe_wr_res.complete=1 at cycle 6 only, outstanding 1→0.
- FE and BE both valid continuously, STARVE_LIMIT=4, sel_wr_ready=1, bank_wr_done every cycle → grant sequence BE,BE,BE,BE,FE,BE,BE,BE,BE,FE; never both ready.
- Backpressure: sel_wr_ready=0 for 3 cycles after first issue → sel_wr_req stable, both readys 0. Release → next grant same cycle.
- Fill: 4 BE writes, no bank_wr_done → outstanding=4, readys 0 with sel_wr_ready=1. One bank_wr_done → be_wr_res pulse and issue resumes the following cycle.
- Ordering: issue FE,BE,FE, then 3 bank_wr_done → fe, be, fe completion pulses in that order.
- bank_wr_done with empty FIFO → err=1 and stays 1. Assert rst with 2 outstanding → outstanding=0, err=0 immediately.
